// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : shares one byte-wide memory port between the page-table
// walker (fixed priority), CPU and DMA (round-robin), with walker bus-lock
// and an ACCESS watchdog.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  input  logic [7:0]        wdata2,
  input  logic              lock0,
  output logic [2:0]        ack,
  output logic [2:0]        err,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_cs,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [1:0]        grant_id
);

  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic            WD_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              rr_q, rr_d;        // 1 = DMA is next in line between CPU/DMA
  logic              lock_q, lock_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [2:0]        ack_q, ack_d;
  logic [2:0]        err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              cs_q, cs_d;

  logic [2:0]        elig;
  logic [1:0]        winner;
  logic              timeout;

  always_comb begin
    elig = (lock_q && req[0] && lock0) ? 3'b001 : req;
    if (elig[0])                 winner = 2'd0;
    else if (elig[1] && elig[2]) winner = rr_q ? 2'd2 : 2'd1;
    else if (elig[1])            winner = 2'd1;
    else                         winner = 2'd2;
  end

  assign timeout = WD_EN && (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    wd_d    = wd_q;
    ack_d   = 3'b000;
    err_d   = 3'b000;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
          owner_d = winner;
          wd_d    = '0;
          cs_d    = 1'b1;
          case (winner)
            2'd0: begin
              addr_d = addr0; wdata_d = wdata0; wr_d = we[0];
            end
            2'd1: begin
              addr_d = addr1; wdata_d = wdata1; wr_d = we[1]; rr_d = 1'b1;
            end
            default: begin
              addr_d = addr2; wdata_d = wdata2; wr_d = we[2]; rr_d = 1'b0;
            end
          endcase
          rd_d = ~wr_d;
        end
      end
      ACCESS: begin
        if (mem_ready || timeout) begin
          state_d = DONE;
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack_d   = 3'b001 << owner_q;
          // A late mem_ready still counts as success even on the final cycle.
          err_d   = mem_ready ? 3'b000 : (3'b001 << owner_q);
          if (mem_ready && rd_q) rdata_d = mem_rdata;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = 2'd3;
        lock_d  = (owner_q == 2'd0) && lock0;
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'd3;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd3;
      rr_q    <= 1'b0;
      lock_q  <= 1'b0;
      wd_q    <= '0;
      ack_q   <= 3'b000;
      err_q   <= 3'b000;
      rdata_q <= 8'h00;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_cs    = cs_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : vector table, directed corner sequences and random
// transactions against a transaction-level arbitration/memory model.
// Revision: 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0, we = '0;
  logic [15:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0, wdata2 = '0;
  logic        lock0 = 1'b0;
  logic [2:0]  ack, err;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_read, mem_write, mem_cs, busy;
  logic        mem_ready = 1'b0;
  logic [1:0]  grant_id;

  logic [7:0]  mem_arr [256];
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .lock0(lock0), .ack(ack), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_cs(mem_cs), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_arr[mem_addr[7:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one transaction from an IDLE negedge; eg/ee/er are the expected owner,
  // abort flag and rdata. lat = ACCESS cycles before mem_ready, 0 = never.
  task automatic do_txn(input logic [2:0] r, input logic [2:0] keep, input int lat,
                        input logic [1:0] eg, input logic ee, input logic [7:0] er,
                        input string nm);
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ew;
    int          acc, exp_acc, n;
    bit          stray;
    ea = (eg == 2'd0) ? addr0  : (eg == 2'd1) ? addr1  : addr2;
    ed = (eg == 2'd0) ? wdata0 : (eg == 2'd1) ? wdata1 : wdata2;
    ew = we[eg];
    exp_acc = (lat == 0) ? TIMEOUT : lat;
    req = r;
    @(negedge clk);
    check({nm, "/grant_id"}, 32'(grant_id), 32'(eg));
    check({nm, "/strobes"}, 32'({mem_cs, mem_read, mem_write}), 32'({1'b1, ~ew, ew}));
    check({nm, "/mem_addr"}, 32'(mem_addr), 32'(ea));
    if (ew) check({nm, "/mem_wdata"}, 32'(mem_wdata), 32'(ed));
    acc = 0;
    stray = 0;
    while (mem_cs === 1'b1 && acc < 300) begin
      acc++;
      if (ack !== 3'b000) stray = 1;
      mem_ready = (lat != 0) && (acc >= lat);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check({nm, "/access_cycles"}, 32'(acc), 32'(exp_acc));
    check({nm, "/early_ack"}, 32'(stray), 32'd0);
    check({nm, "/ack"}, 32'(ack), 32'(3'b001 << eg));
    check({nm, "/err"}, 32'(err), 32'(ee ? (3'b001 << eg) : 3'b000));
    check({nm, "/rdata"}, 32'(rdata), 32'(er));
    check({nm, "/done_state"}, 32'({mem_cs, mem_read, mem_write, busy, grant_id}),
          32'({3'b000, 1'b1, eg}));
    if (ew && !ee) mem_arr[ea[7:0]] = ed;
    req = keep;
    @(negedge clk);
    check({nm, "/idle"}, 32'({busy, grant_id, ack}), 32'({1'b0, 2'd3, 3'b000}));
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [2:0]  r;
    logic [2:0]  w;
    logic [15:0] a;
    logic [7:0]  d;
    int          lat;
    logic [7:0]  mval;
    logic [1:0]  eg;
    logic [7:0]  er;
  } vec_t;

  vec_t vt [9];

  // Spec-level arbitration: walker first, otherwise the CPU/DMA master
  // that was not served most recently.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last_cd);
    if (r[0])            return 2'd0;
    if (r[1] && r[2])    return (last_cd == 2'd1) ? 2'd2 : 2'd1;
    return r[1] ? 2'd1 : 2'd2;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0]  last_cd, w;
    logic [2:0]  r;
    logic [7:0]  exp_rd;
    logic [15:0] wa;
    int          lat;

    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;

    @(negedge clk);
    @(negedge clk);
    check("reset/ack_err", 32'({ack, err}), 32'd0);
    check("reset/rdata", 32'(rdata), 32'd0);
    check("reset/mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
    check("reset/strobes", 32'({mem_cs, mem_read, mem_write}), 32'd0);
    check("reset/busy_gid", 32'({busy, grant_id}), 32'({1'b0, 2'd3}));
    rst_n = 1'b1;
    @(negedge clk);

    vt[0] = '{3'b010, 3'b000, 16'h1234, 8'h00, 2, 8'hA5, 2'd1, 8'hA5};
    vt[1] = '{3'b100, 3'b111, 16'h8000, 8'h3C, 1, 8'h00, 2'd2, 8'hA5};
    vt[2] = '{3'b110, 3'b000, 16'h0042, 8'h00, 1, 8'h5A, 2'd1, 8'h5A};
    vt[3] = '{3'b110, 3'b000, 16'h0043, 8'h00, 3, 8'h77, 2'd2, 8'h77};
    vt[4] = '{3'b111, 3'b000, 16'h0044, 8'h00, 1, 8'h11, 2'd0, 8'h11};
    vt[5] = '{3'b110, 3'b111, 16'h0045, 8'hEE, 2, 8'h00, 2'd1, 8'h11};
    vt[6] = '{3'b101, 3'b000, 16'h0046, 8'h00, 1, 8'h99, 2'd0, 8'h99};
    vt[7] = '{3'b110, 3'b000, 16'h0047, 8'h00, 1, 8'hC3, 2'd2, 8'hC3};
    vt[8] = '{3'b001, 3'b111, 16'h0048, 8'h05, 4, 8'h00, 2'd0, 8'hC3};
    for (int i = 0; i < 9; i++) begin
      addr0 = vt[i].a; addr1 = vt[i].a; addr2 = vt[i].a;
      wdata0 = vt[i].d; wdata1 = vt[i].d; wdata2 = vt[i].d;
      we = vt[i].w;
      mem_arr[vt[i].a[7:0]] = vt[i].mval;
      do_txn(vt[i].r, 3'b000, vt[i].lat, vt[i].eg, 1'b0, vt[i].er, $sformatf("vec%0d", i));
    end
    check("vec8/mem_written", 32'(mem_arr[8'h48]), 32'h05);

    // All three request; walker comes back only once DMA has been granted.
    we = 3'b000;
    addr0 = 16'h0100; addr1 = 16'h0101; addr2 = 16'h0102;
    mem_arr[0] = 8'hA0; mem_arr[1] = 8'hA1; mem_arr[2] = 8'hA2;
    do_txn(3'b111, 3'b110, 1, 2'd0, 1'b0, 8'hA0, "order0");
    do_txn(3'b110, 3'b100, 1, 2'd1, 1'b0, 8'hA1, "order1");
    do_txn(3'b100, 3'b001, 1, 2'd2, 1'b0, 8'hA2, "order2");
    do_txn(3'b011, 3'b000, 1, 2'd0, 1'b0, 8'hA0, "order3");

    // Walker bus lock across two fetches while the CPU waits.
    lock0 = 1'b1;
    addr0 = 16'hE000;
    do_txn(3'b011, 3'b011, 1, 2'd0, 1'b0, 8'hA0, "lock_e000");
    addr0 = 16'hE001;
    do_txn(3'b011, 3'b010, 2, 2'd0, 1'b0, 8'hA1, "lock_e001");
    lock0 = 1'b0;
    do_txn(3'b010, 3'b000, 1, 2'd1, 1'b0, 8'hA1, "lock_release_cpu");

    do_txn(3'b100, 3'b000, 0, 2'd2, 1'b1, 8'hA1, "timeout_dma");

    last_cd = 2'd2;
    exp_rd = 8'hA1;
    for (int t = 0; t < 60; t++) begin
      r = 3'($urandom_range(1, 7));
      we = 3'($urandom_range(0, 7));
      addr0 = 16'($urandom); addr1 = 16'($urandom); addr2 = 16'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom); wdata2 = 8'($urandom);
      lock0 = 1'($urandom_range(0, 1));
      lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4));
      w = pick(r, last_cd);
      if (w != 2'd0) last_cd = w;
      wa = (w == 2'd0) ? addr0 : (w == 2'd1) ? addr1 : addr2;
      if (lat != 0 && !we[w]) exp_rd = mem_arr[wa[7:0]];
      do_txn(r, 3'b000, lat, w, (lat == 0), exp_rd, $sformatf("rnd%0d", t));
    end
    lock0 = 1'b0;

    // Asynchronous reset in the middle of a CPU access (CPU grant moved rr to DMA).
    we = 3'b000;
    addr1 = 16'h0101;
    req = 3'b010;
    @(negedge clk);
    check("rst_mid/in_access", 32'(mem_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid/strobes", 32'({mem_cs, mem_read, mem_write}), 32'd0);
    check("rst_mid/busy_ack", 32'({busy, ack, err}), 32'd0);
    check("rst_mid/gid_rdata", 32'({grant_id, rdata}), 32'({2'd3, 8'h00}));
    req = 3'b000;
    @(negedge clk);
    check("rst_mid/no_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(3'b110, 3'b000, 1, 2'd1, 1'b0, mem_arr[8'h01], "rst_cpu_first");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
